// File: rtl/mul_pipe_pkg.sv
// Shared constants and lane-slicing helpers for the mul_pipe multiplier.
// The optional per-lane accumulators are enabled with MUL_PIPE_ACC_EN.
package mul_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_LANES       = 4;
    localparam int DEF_PIPE_STAGES = 2;
    localparam int ACC_GUARD       = 4;

    // Bit offset of lane 'lane' inside a packed operand vector.
    function automatic int op_lsb(input int lane, input int data_w);
        return lane * data_w;
    endfunction

    function automatic int prod_lsb(input int lane, input int data_w);
        return lane * 2 * data_w;
    endfunction

    function automatic int acc_width(input int data_w);
        return 2 * data_w + ACC_GUARD;
    endfunction

endpackage

// File: rtl/mul_pipe_if.sv
// Transaction bus between the line-buffer window and mul_pipe.
// acc_first/acc_result exist only when MUL_PIPE_ACC_EN is defined.
interface mul_pipe_if
    import mul_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES
);

    logic                        in_valid;
    logic                        in_signed;
    logic [LANES*DATA_W-1:0]     dataa;
    logic [LANES*DATA_W-1:0]     datab;
    logic                        out_valid;
    logic [LANES*2*DATA_W-1:0]   result;
`ifdef MUL_PIPE_ACC_EN
    logic                                  acc_first;
    logic [LANES*(2*DATA_W+ACC_GUARD)-1:0] acc_result;
`endif

    modport master (
        output in_valid, in_signed, dataa, datab,
`ifdef MUL_PIPE_ACC_EN
        output acc_first,
        input  acc_result,
`endif
        input  out_valid, result
    );

    modport slave (
        input  in_valid, in_signed, dataa, datab,
`ifdef MUL_PIPE_ACC_EN
        input  acc_first,
        output acc_result,
`endif
        output out_valid, result
    );

endinterface

// File: rtl/mul_lane.sv
// One multiplier lane: operand extension, exact 2*DATA_W product and data pipeline.
// Valid/sign tracking is shared and lives in mul_pipe.
module mul_lane #(
    parameter int DATA_W      = 8,
    parameter int PIPE_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic                  op_signed,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   prod
);

    localparam int PW = 2 * DATA_W;

    // Low 2*DATA_W bits of the extended product are exact in both modes.
    function automatic logic [PW-1:0] mult(input logic [DATA_W-1:0] x,
                                           input logic [DATA_W-1:0] y,
                                           input logic              s);
        logic [PW-1:0] xe;
        logic [PW-1:0] ye;
        xe = {{DATA_W{s & x[DATA_W-1]}}, x};
        ye = {{DATA_W{s & y[DATA_W-1]}}, y};
        return xe * ye;
    endfunction

    generate
        if (PIPE_STAGES == 1) begin : g_direct
            logic [PW-1:0] prod_q;

            always_ff @(posedge clock) begin
                if (!reset_n)
                    prod_q <= '0;
                else if (clken)
                    prod_q <= mult(a, b, op_signed);
            end

            assign prod = prod_q;
        end else begin : g_staged
            logic [DATA_W-1:0] a_q;
            logic [DATA_W-1:0] b_q;
            logic [PW-1:0]     prod_q [1:PIPE_STAGES-1];

            // Operands are registered first so the multiplier sits between two flops.
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    for (int i = 1; i < PIPE_STAGES; i++)
                        prod_q[i] <= '0;
                end else if (clken) begin
                    a_q       <= a;
                    b_q       <= b;
                    prod_q[1] <= mult(a_q, b_q, op_signed);
                    for (int i = 2; i < PIPE_STAGES; i++)
                        prod_q[i] <= prod_q[i-1];
                end
            end

            assign prod = prod_q[PIPE_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/mul_pipe.sv
// Multi-lane pipelined multiplier with shared valid/sign tracking.
// Define MUL_PIPE_ACC_EN to add one wrapping accumulator per lane.
module mul_pipe
    import mul_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int LANES       = DEF_LANES,
    parameter int PIPE_STAGES = DEF_PIPE_STAGES
) (
    input  logic     clock,
    input  logic     reset_n,
    input  logic     clken,
    mul_pipe_if.slave bus
);

    localparam int PW = 2 * DATA_W;

    generate
        if (PIPE_STAGES < 1) begin : g_bad_stages
            $error("mul_pipe: PIPE_STAGES must be >= 1");
        end
        if (DATA_W < 2) begin : g_bad_width
            $error("mul_pipe: DATA_W must be >= 2");
        end
    endgenerate

`ifdef MUL_PIPE_ACC_EN
    localparam int CTRL_DEPTH = PIPE_STAGES;
`else
    localparam int CTRL_DEPTH = 1;
`endif

    logic [PIPE_STAGES-1:0] valid_q;
    logic [CTRL_DEPTH-1:0]  sgn_q;
    logic                   mul_signed;
    logic                   out_valid;
    logic [LANES*PW-1:0]    prod;
`ifdef MUL_PIPE_ACC_EN
    logic [PIPE_STAGES-1:0] first_q;
`endif

    // Control bits ride alongside the data so mode changes never touch older slots.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            valid_q <= '0;
            sgn_q   <= '0;
`ifdef MUL_PIPE_ACC_EN
            first_q <= '0;
`endif
        end else if (clken) begin
            valid_q[0] <= bus.in_valid;
            sgn_q[0]   <= bus.in_signed;
            for (int i = 1; i < PIPE_STAGES; i++)
                valid_q[i] <= valid_q[i-1];
            for (int i = 1; i < CTRL_DEPTH; i++)
                sgn_q[i] <= sgn_q[i-1];
`ifdef MUL_PIPE_ACC_EN
            first_q[0] <= bus.acc_first;
            for (int i = 1; i < PIPE_STAGES; i++)
                first_q[i] <= first_q[i-1];
`endif
        end
    end

    assign mul_signed = (PIPE_STAGES == 1) ? bus.in_signed : sgn_q[0];
    assign out_valid  = valid_q[PIPE_STAGES-1];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        mul_lane #(
            .DATA_W      (DATA_W),
            .PIPE_STAGES (PIPE_STAGES)
        ) u_lane (
            .clock     (clock),
            .reset_n   (reset_n),
            .clken     (clken),
            .op_signed (mul_signed),
            .a         (bus.dataa[op_lsb(l, DATA_W) +: DATA_W]),
            .b         (bus.datab[op_lsb(l, DATA_W) +: DATA_W]),
            .prod      (prod[prod_lsb(l, DATA_W) +: PW])
        );
    end

    assign bus.out_valid = out_valid;
    assign bus.result    = prod;

`ifdef MUL_PIPE_ACC_EN
    localparam int AW = acc_width(DATA_W);

    logic last_first;
    logic last_signed;

    assign last_first  = first_q[PIPE_STAGES-1];
    assign last_signed = sgn_q[CTRL_DEPTH-1];

    // acc_q holds the total up to the previous output; acc_now folds in the
    // product on display so acc_result changes together with out_valid.
    for (genvar l = 0; l < LANES; l++) begin : g_acc
        logic [AW-1:0] acc_q;
        logic [AW-1:0] acc_now;
        logic [AW-1:0] prod_ext;

        assign prod_ext = {{ACC_GUARD{last_signed & prod[prod_lsb(l, DATA_W) + PW - 1]}},
                           prod[prod_lsb(l, DATA_W) +: PW]};

        always_comb begin
            acc_now = acc_q;
            if (out_valid)
                acc_now = last_first ? prod_ext : acc_q + prod_ext;
        end

        always_ff @(posedge clock) begin
            if (!reset_n)
                acc_q <= '0;
            else if (clken && out_valid)
                acc_q <= acc_now;
        end

        assign bus.acc_result[l*AW +: AW] = acc_now;
    end
`endif

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe: directed vectors, stall, reset flush and random traffic.
// Accumulator expectations are included when MUL_PIPE_ACC_EN is defined.
module tb_mul_pipe;
    import mul_pkg::*;

    localparam int DW = 8;
    localparam int LN = 4;
    localparam int PS = 2;
    localparam int PW = 2 * DW;
    localparam int AW = PW + ACC_GUARD;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic clken   = 1'b0;

    always #5 clock = ~clock;

    mul_pipe_if #(.DATA_W(DW), .LANES(LN)) bus ();

    mul_pipe #(
        .DATA_W      (DW),
        .LANES       (LN),
        .PIPE_STAGES (PS)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .clken   (clken),
        .bus     (bus)
    );

    typedef struct {
        logic [LN*PW-1:0] res;
        logic [LN*AW-1:0] acc;
        int               due;
    } sb_entry_t;

    sb_entry_t     sb[$];
    int            tests_run    = 0;
    int            tests_failed = 0;
    int            en_cnt       = 0;
    bit            adv;
    logic [AW-1:0] acc_model [LN];

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] model_prod(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                                 input logic s);
        longint x;
        longint y;
        longint p;
        x = s ? longint'($signed(a)) : longint'(a);
        y = s ? longint'($signed(b)) : longint'(b);
        p = x * y;
        return p[PW-1:0];
    endfunction

    // Drives one slot at the falling edge and queues its expected output.
    task automatic applyStimulus(input logic v, input logic s, input logic f,
                                 input logic [LN*DW-1:0] a, input logic [LN*DW-1:0] b,
                                 input logic [LN*PW-1:0] exp);
        @(negedge clock);
        clken         = 1'b1;
        bus.in_valid  = v;
        bus.in_signed = s;
        bus.dataa     = a;
        bus.datab     = b;
`ifdef MUL_PIPE_ACC_EN
        bus.acc_first = f;
`endif
        if (v) begin
            sb_entry_t e;
            e.res = exp;
            e.due = en_cnt + PS;
            for (int l = 0; l < LN; l++) begin
                logic [PW-1:0] p;
                logic [AW-1:0] pe;
                p  = exp[l*PW +: PW];
                pe = {{ACC_GUARD{s & p[PW-1]}}, p};
                acc_model[l] = f ? pe : acc_model[l] + pe;
                e.acc[l*AW +: AW] = acc_model[l];
            end
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // Output monitor: only clken-qualified, non-reset edges produce a slot.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clock);
            adv = clken && reset_n;
            if (adv) en_cnt++;
            #1;
            if (adv) begin
                while (sb.size() > 0 && sb[0].due < en_cnt) begin
                    checkOutput("missing_output", en_cnt, sb[0].due);
                    sb.delete(0);
                end
                if (bus.out_valid) begin
                    if (sb.size() == 0) begin
                        checkOutput("spurious_valid", bus.out_valid, 1'b0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("result", bus.result, e.res);
                        checkOutput("latency", en_cnt, e.due);
`ifdef MUL_PIPE_ACC_EN
                        checkOutput("acc_result", bus.acc_result, e.acc);
`endif
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [LN*DW-1:0] ra;
        logic [LN*DW-1:0] rb;
        logic [LN*PW-1:0] rexp;
        logic             rs;

        bus.in_valid  = 1'b0;
        bus.in_signed = 1'b0;
        bus.dataa     = '0;
        bus.datab     = '0;
`ifdef MUL_PIPE_ACC_EN
        bus.acc_first = 1'b0;
`endif
        for (int l = 0; l < LN; l++) acc_model[l] = '0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        checkOutput("reset_out_valid", bus.out_valid, 1'b0);
        checkOutput("reset_result", bus.result, '0);
`ifdef MUL_PIPE_ACC_EN
        checkOutput("reset_acc", bus.acc_result, '0);
`endif

        // Back-to-back unsigned on lane 0, then signed vs unsigned of the same operands.
        applyStimulus(1'b1, 1'b0, 1'b1, {24'd0, 8'd5},  {24'd0, 8'd10}, {48'd0, 16'd50});
        applyStimulus(1'b1, 1'b0, 1'b0, {24'd0, 8'd11}, {24'd0, 8'd10}, {48'd0, 16'd110});
        applyStimulus(1'b1, 1'b0, 1'b0, {24'd0, 8'd3},  {24'd0, 8'd10}, {48'd0, 16'd30});
        applyStimulus(1'b1, 1'b1, 1'b1, {24'd0, 8'hFD}, {24'd0, 8'd10}, {48'd0, 16'hFFE2});
        applyStimulus(1'b1, 1'b0, 1'b0, {24'd0, 8'hFD}, {24'd0, 8'd10}, {48'd0, 16'h09E2});

        // Extremes, every lane carrying a different pair.
        applyStimulus(1'b1, 1'b0, 1'b1,
                      {8'd200, 8'd1, 8'h80, 8'hFF}, {8'd3, 8'hFF, 8'h80, 8'hFF},
                      {16'h0258, 16'h00FF, 16'h4000, 16'hFE01});
        applyStimulus(1'b1, 1'b1, 1'b0,
                      {8'h7F, 8'h80, 8'hFF, 8'h80}, {8'h7F, 8'h7F, 8'hFF, 8'h80},
                      {16'h3F01, 16'hC080, 16'h0001, 16'h4000});
        applyStimulus(1'b1, 1'b0, 1'b1, {24'd0, 8'd3}, {24'd0, 8'd3}, {48'd0, 16'd9});
        idle(PS + 2);

        // Stall with one result at the output and the next one mid-pipe.
        applyStimulus(1'b1, 1'b0, 1'b1, {24'd0, 8'd7}, {24'd0, 8'd6}, {48'd0, 16'd42});
        applyStimulus(1'b1, 1'b0, 1'b0, {24'd0, 8'd9}, {24'd0, 8'd9}, {48'd0, 16'd81});
        @(negedge clock);
        clken        = 1'b0;
        bus.in_valid = 1'b1;
        bus.dataa    = 32'hA5A5_A5A5;
        bus.datab    = 32'h5A5A_5A5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("stall1_valid", bus.out_valid, 1'b1);
            checkOutput("stall1_result", bus.result, {48'd0, 16'd42});
`ifdef MUL_PIPE_ACC_EN
            checkOutput("stall1_acc", bus.acc_result, {60'd0, 20'd42});
`endif
        end
        clken        = 1'b1;
        bus.in_valid = 1'b0;
        bus.dataa    = '0;
        bus.datab    = '0;
        @(negedge clock);
        clken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("stall2_valid", bus.out_valid, 1'b1);
            checkOutput("stall2_result", bus.result, {48'd0, 16'd81});
        end
        idle(PS + 2);

        // Reset with two transactions in flight: neither may ever emerge.
        applyStimulus(1'b1, 1'b0, 1'b1, {24'd0, 8'd4}, {24'd0, 8'd4}, {48'd0, 16'd16});
        @(negedge clock);
        clken        = 1'b1;
        bus.in_valid = 1'b1;
        bus.dataa    = {24'd0, 8'd5};
        bus.datab    = {24'd0, 8'd5};
        reset_n      = 1'b0;
        sb.delete();
        for (int l = 0; l < LN; l++) acc_model[l] = '0;
        @(negedge clock);
        reset_n      = 1'b1;
        bus.in_valid = 1'b0;
        bus.dataa    = '0;
        bus.datab    = '0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("post_reset_valid", bus.out_valid, 1'b0);
            checkOutput("post_reset_result", bus.result, '0);
`ifdef MUL_PIPE_ACC_EN
            checkOutput("post_reset_acc", bus.acc_result, '0);
`endif
            @(negedge clock);
        end
        applyStimulus(1'b1, 1'b1, 1'b1,
                      {8'd2, 8'd3, 8'd4, 8'hFE}, {8'hFF, 8'd5, 8'd6, 8'd7},
                      {16'hFFFE, 16'h000F, 16'h0018, 16'hFFF2});

        // Random traffic with bubbles and per-slot mode changes.
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            for (int l = 0; l < LN; l++)
                rexp[l*PW +: PW] = model_prod(ra[l*DW +: DW], rb[l*DW +: DW], rs);
            applyStimulus($urandom_range(0, 3) != 0, rs, $urandom_range(0, 4) == 0, ra, rb, rexp);
        end
        idle(PS + 3);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
- Parametrised, fully pipelined multi-lane multiplier for the convolution datapath.
- Successor to the fixed 8x8 two-stage multiplier. Adds:
  - LANES parallel products
  - configurable width and latency
  - per-transaction signed/unsigned mode
  - valid tracking through the pipeline
- Feeds the kernel-tap adder tree. Consumes pixel/weight pairs from the line-buffer window.

Parameters:
- DATA_W, 8, operand width per lane (bits); must be >= 2.
- LANES, 4, number of independent multiplier lanes.
- PIPE_STAGES, 2, register stages from input to result; must be >= 1, elaboration error otherwise.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- clken  input  1  pipeline advance enable; low freezes every stage.
- in_valid  input  1  dataa/datab/in_signed carry a transaction this cycle.
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- dataa  input  LANES*DATA_W  packed operand A; lane i at bits [i*DATA_W +: DATA_W].
- datab  input  LANES*DATA_W  packed operand B, same packing.
- out_valid  output  1  result holds a completed transaction.
- result  output  LANES*2*DATA_W  packed products; lane i at [i*2*DATA_W +: 2*DATA_W].

Behaviour:
- Reset (reset_n low at a clock edge):
  - Clears all valid bits, all data stages, out_valid and result to 0.
  - Takes priority over clken.
  - Transactions in flight are discarded and never appear at the output.
- Advance:
  - On an edge with clken=1, every stage shifts one step. Stage 0 captures dataa, datab, in_signed and in_valid.
  - On an edge with clken=0, all stages, including valid bits and the output, hold.
- Latency: exactly PIPE_STAGES clken-qualified edges from capture to out_valid=1 with the matching result.
- Throughput: one transaction per clken cycle. No bubbles are required between back-to-back in_valid.
- Signed mode travels with its transaction. Changing in_signed mid-stream must not affect transactions already in flight.
- Arithmetic:
  - Signed: both operands sign-extended to 2*DATA_W; exact product.
  - Unsigned: zero-extended; exact product.
  - No overflow is possible at 2*DATA_W.
- in_valid=0 transactions propagate as bubbles: out_valid=0 for that slot.
  - result content in a bubble slot is don't-care, but must not be X after reset.
- Lanes are independent. All lanes share valid, signed and clken.
- No backpressure input: downstream must accept whenever out_valid=1.

Optional Feature:
- Macro: MUL_PIPE_ACC_EN.
- When defined, the block adds:
  - Input acc_first (1 bit), which travels with the transaction.
  - Output acc_result (LANES*(2*DATA_W+4)), one accumulator per lane.
- Accumulator update, on each edge where the final stage presents a valid transaction and clken=1:
  - acc_first=1: accumulator loads the sign/zero-extended product.
  - acc_first=0: accumulator adds the product, wrapping modulo 2^(2*DATA_W+4).
- Reset clears the accumulators. clken=0 holds them.
- acc_result is updated in the same cycle as out_valid.
- When the macro is not defined, neither port nor accumulator exists, and behaviour is as above.

Decomposition:
- Shared package mul_pkg holds:
  - default DATA_W/LANES/PIPE_STAGES localparams
  - ACC_GUARD=4
  - lane-slice helper functions for packed vectors
- Sub-module mul_lane: one lane's operand extension, multiply and data pipeline.
- mul_pipe instantiates LANES of mul_lane and owns the shared valid/signed pipeline and the optional accumulators.

Test Plan:
- Defaults, lane0: a=5,b=10, then 11*10, then 3*10, back-to-back, in_signed=0.
  - Expect out_valid on edges 2,3,4 after capture, with result 50, 110, 30.
- Signed: a=8'hFD (-3), b=10, in_signed=1 -> lane result 16'hFFE2.
  - Same operands with in_signed=0 -> 16'h09E2 (2530).
- Extremes, unsigned 255*255 -> 16'hFE01; signed 8'h80*8'h80 -> 16'h4000.
  - All four lanes carry different pairs in the same cycle; each checked independently.
- Stall: issue one transaction, drop clken for 3 cycles mid-pipe.
  - out_valid and result frozen during the stall.
  - Result appears PIPE_STAGES enabled edges after capture.
- Reset: assert reset_n=0 for one edge with two transactions in flight.
  - out_valid stays 0 and result is 0 afterwards.
  - The next transaction has normal latency.
- With MUL_PIPE_ACC_EN: products 50 (acc_first=1), 110, 30 -> acc_result lane0 = 50, 160, 190.
  - A new acc_first=1 with 3*3 -> 9.
